// File: rtl/distribution_demux_pkg.sv
// distribution_demux_pkg: constants and helpers shared by the scatter demux, its lane FIFOs and the reduction mux
package distribution_demux_pkg;

    localparam int DIST_FIFO_DEPTH = 2;
    localparam int DEFAULT_W       = 32;
    localparam int DEFAULT_NUM_OUT = 4;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/distribution_demux_lane_fifo.sv
// dist_lane_fifo: two-entry lane buffer; the head always lives in head_q so the output never needs a read mux
module dist_lane_fifo
    import distribution_demux_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic [1:0]   count
);

    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic [1:0]   count_q, count_d;
    logic         do_push, do_pop, to_head;

    always_comb begin
        do_pop  = pop && (count_q != 2'd0);
        do_push = push && (count_q < 2'(DIST_FIFO_DEPTH));
        to_head = (count_q == 2'd0) || (do_pop && count_q == 2'd1);
        head_d  = (do_push && to_head) ? push_data : (do_pop ? tail_q : head_q);
        tail_d  = (do_push && !to_head) ? push_data : tail_q;
        count_d = count_q + 2'(do_push) - 2'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Stale slots are masked so an empty lane always presents zero
    assign head_data = (count_q != 2'd0) ? head_q : '0;
    assign count     = count_q;

endmodule

// File: rtl/distribution_demux.sv
// distribution_demux: scatters a tagged word stream into per-lane two-entry buffers, with broadcast and drop counting
module distribution_demux
    import distribution_demux_pkg::*;
#(
    parameter int W       = DEFAULT_W,
    parameter int NUM_OUT = DEFAULT_NUM_OUT,
    parameter int SEL_W   = 2,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [W-1:0]         i_data,
    input  logic [SEL_W-1:0]     i_dest,
    input  logic                 i_bcast,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic [NUM_OUT*W-1:0] o_data,
    output logic [NUM_OUT-1:0]   o_valid,
    input  logic [NUM_OUT-1:0]   i_ready,
    output logic [CNT_W-1:0]     o_drop_cnt
);

    localparam logic [SEL_W:0] LANES = (SEL_W + 1)'(NUM_OUT);

    logic [NUM_OUT-1:0] push, full;
    logic               in_range, sel_full, xfer, drop;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

    if (NUM_OUT < 2 || SEL_W < clog2(NUM_OUT)) begin : g_bad_params
        $error("distribution_demux: NUM_OUT must be >= 2 and SEL_W >= clog2(NUM_OUT)");
    end

    // o_ready depends only on registered lane fullness, never on i_ready
    always_comb begin
        in_range = {1'b0, i_dest} < LANES;
        sel_full = 1'b0;
        for (int k = 0; k < NUM_OUT; k++) sel_full = sel_full | (full[k] && (i_dest == SEL_W'(k)));
        o_ready  = rst && (i_bcast ? !(|full) : (!in_range || !sel_full));
        xfer     = i_valid && o_ready;
        drop     = xfer && !i_bcast && !in_range;
        for (int k = 0; k < NUM_OUT; k++) push[k] = xfer && (i_bcast || (i_dest == SEL_W'(k)));
        drop_cnt_d = (drop && (drop_cnt_q != '1)) ? drop_cnt_q + CNT_W'(1) : drop_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) drop_cnt_q <= '0;
        else drop_cnt_q <= drop_cnt_d;
    end

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_lane
        logic [1:0] count;
        dist_lane_fifo #(.W(W)) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push[k]),
            .push_data (i_data),
            .pop       (i_ready[k]),
            .head_data (o_data[k*W +: W]),
            .count     (count)
        );
        assign o_valid[k] = count != 2'd0;
        assign full[k]    = count == 2'(DIST_FIFO_DEPTH);
    end

    assign o_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_distribution_demux.sv
// tb_distribution_demux: scoreboard bench for the scatter demux (4-lane main instance plus two 3-lane drop-counter builds)
module tb_distribution_demux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [31:0]  i_data;
    logic [1:0]   i_dest;
    logic         i_bcast, i_valid;
    logic [3:0]   i_ready;
    logic         o_ready;
    logic [127:0] o_data;
    logic [3:0]   o_valid;
    logic [15:0]  o_drop_cnt;

    logic         s_valid;
    logic [1:0]   s_dest;
    logic [31:0]  s_data;
    logic         s_ready_a, s_ready_b;
    logic [95:0]  s_data_a, s_data_b;
    logic [2:0]   s_valid_a, s_valid_b;
    logic [15:0]  s_drop_a;
    logic [1:0]   s_drop_b;

    logic [31:0] sb [4][$];
    int drop_a, drop_b;
    int n_cmp = 0;
    int n_fail = 0;

    distribution_demux #(.W(32), .NUM_OUT(4), .SEL_W(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .i_data(i_data), .i_dest(i_dest), .i_bcast(i_bcast),
        .i_valid(i_valid), .o_ready(o_ready), .o_data(o_data), .o_valid(o_valid),
        .i_ready(i_ready), .o_drop_cnt(o_drop_cnt)
    );

    distribution_demux #(.W(32), .NUM_OUT(3), .SEL_W(2), .CNT_W(16)) dut_n3 (
        .clk(clk), .rst(rst), .i_data(s_data), .i_dest(s_dest), .i_bcast(1'b0),
        .i_valid(s_valid), .o_ready(s_ready_a), .o_data(s_data_a), .o_valid(s_valid_a),
        .i_ready(3'b111), .o_drop_cnt(s_drop_a)
    );

    distribution_demux #(.W(32), .NUM_OUT(3), .SEL_W(2), .CNT_W(2)) dut_c2 (
        .clk(clk), .rst(rst), .i_data(s_data), .i_dest(s_dest), .i_bcast(1'b0),
        .i_valid(s_valid), .o_ready(s_ready_b), .o_data(s_data_b), .o_valid(s_valid_b),
        .i_ready(3'b111), .o_drop_cnt(s_drop_b)
    );

    function automatic logic exp_rdy();
        if (!rst) return 1'b0;
        if (i_bcast) begin
            for (int k = 0; k < 4; k++) if (sb[k].size() >= 2) return 1'b0;
            return 1'b1;
        end
        return sb[i_dest].size() < 2;
    endfunction

    task automatic set_in(input logic v, input logic [1:0] d, input logic b,
                          input logic [31:0] data, input logic [3:0] rdy);
        i_valid = v;
        i_dest  = d;
        i_bcast = b;
        i_data  = data;
        i_ready = rdy;
        #1;
    endtask

    // Advances the reference model by one edge, then the DUT
    task automatic tick();
        logic r;
        r = exp_rdy();
        if (!rst) begin
            for (int k = 0; k < 4; k++) sb[k].delete();
            drop_a = 0;
            drop_b = 0;
        end else begin
            for (int k = 0; k < 4; k++) if (sb[k].size() != 0 && i_ready[k]) void'(sb[k].pop_front());
            if (i_valid && r) begin
                if (i_bcast) for (int k = 0; k < 4; k++) sb[k].push_back(i_data);
                else sb[i_dest].push_back(i_data);
            end
            if (s_valid && s_dest >= 2'd3) begin
                drop_a++;
                if (drop_b < 3) drop_b++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        s_valid = 1'b0;
        s_dest = 2'd0;
        s_data = 32'h0;
        set_in(1'b1, 2'd0, 1'b0, 32'hDEAD, 4'h0);
        n_cmp++;
        if (o_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", o_ready); end
        tick();
        tick();
        set_in(1'b0, 2'd0, 1'b0, 32'h0, 4'h0);
        n_cmp++;
        if (o_valid !== 4'h0 || o_data !== 128'h0) begin n_fail++; $display("FAIL reset_lanes: got v=%h d=%h want 0", o_valid, o_data); end
        n_cmp++;
        if (o_drop_cnt !== 16'h0 || s_drop_a !== 16'h0 || s_drop_b !== 2'h0) begin n_fail++; $display("FAIL reset_drop: got %0d/%0d/%0d want 0", o_drop_cnt, s_drop_a, s_drop_b); end
        rst = 1'b1;
        #1;
    endtask

    task automatic test_unicast_fill();
        logic [31:0] words [3];
        words = '{32'hA0, 32'hA1, 32'hA2};
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 2'd2, 1'b0, words[i], 4'h0);
            n_cmp++;
            if (o_ready !== exp_rdy() || o_ready !== (i < 2)) begin n_fail++; $display("FAIL fill_ready[%0d]: got %b want %b", i, o_ready, i < 2); end
            if (i == 2) begin
                n_cmp++;
                if (o_valid !== 4'b0100 || o_data[95:64] !== 32'hA0 || o_data[63:0] !== 64'h0 || o_data[127:96] !== 32'h0) begin
                    n_fail++;
                    $display("FAIL fill_head: got v=%b lane2=%h want v=0100 lane2=a0", o_valid, o_data[95:64]);
                end
            end
            tick();
        end
    endtask

    task automatic test_pop_refill();
        logic [31:0] e;
        int got;
        set_in(1'b1, 2'd2, 1'b0, 32'hA2, 4'b0100);
        n_cmp++;
        if (o_ready !== 1'b0) begin n_fail++; $display("FAIL pop_same_cycle_ready: got %b want 0", o_ready); end
        tick();
        set_in(1'b1, 2'd2, 1'b0, 32'hA2, 4'h0);
        n_cmp++;
        if (o_ready !== 1'b1 || o_data[95:64] !== 32'hA1) begin n_fail++; $display("FAIL pop_next_ready: got r=%b head=%h want r=1 head=a1", o_ready, o_data[95:64]); end
        tick();
        set_in(1'b0, 2'd0, 1'b0, 32'h0, 4'b0100);
        got = 0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) begin
                e = sb[k].size() != 0 ? sb[k][0] : 32'h0;
                n_cmp++;
                if (o_valid[k] !== (sb[k].size() != 0) || o_data[k*32 +: 32] !== e) begin
                    n_fail++;
                    $display("FAIL pop_drain lane%0d: got v=%b d=%h want v=%b d=%h", k, o_valid[k], o_data[k*32 +: 32], sb[k].size() != 0, e);
                end
            end
            if (o_valid[2]) got++;
            tick();
        end
        n_cmp++;
        if (got != 2) begin n_fail++; $display("FAIL pop_drain_count: got %0d want 2", got); end
    endtask

    task automatic test_bcast();
        logic [31:0] e;
        set_in(1'b1, 2'd1, 1'b0, 32'h10, 4'h0);
        tick();
        set_in(1'b1, 2'd1, 1'b0, 32'h11, 4'h0);
        tick();
        set_in(1'b1, 2'd0, 1'b1, 32'h55, 4'h0);
        n_cmp++;
        if (o_ready !== 1'b0) begin n_fail++; $display("FAIL bcast_blocked_ready: got %b want 0", o_ready); end
        tick();
        n_cmp++;
        if (o_valid !== 4'b0010 || o_data[63:32] !== 32'h10) begin n_fail++; $display("FAIL bcast_blocked_lanes: got v=%b lane1=%h want 0010/10", o_valid, o_data[63:32]); end
        set_in(1'b1, 2'd0, 1'b1, 32'h55, 4'b0010);
        n_cmp++;
        if (o_ready !== 1'b0) begin n_fail++; $display("FAIL bcast_pop_ready: got %b want 0", o_ready); end
        tick();
        set_in(1'b1, 2'd0, 1'b1, 32'h55, 4'h0);
        n_cmp++;
        if (o_ready !== 1'b1) begin n_fail++; $display("FAIL bcast_accept_ready: got %b want 1", o_ready); end
        tick();
        set_in(1'b0, 2'd0, 1'b0, 32'h0, 4'h0);
        n_cmp++;
        if (o_valid !== 4'hF || o_data !== {32'h55, 32'h55, 32'h11, 32'h55}) begin n_fail++; $display("FAIL bcast_delivered: got v=%h d=%h", o_valid, o_data); end
        set_in(1'b0, 2'd0, 1'b0, 32'h0, 4'hF);
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < 4; k++) begin
                e = sb[k].size() != 0 ? sb[k][0] : 32'h0;
                n_cmp++;
                if (o_valid[k] !== (sb[k].size() != 0) || o_data[k*32 +: 32] !== e) begin
                    n_fail++;
                    $display("FAIL bcast_drain lane%0d: got v=%b d=%h want v=%b d=%h", k, o_valid[k], o_data[k*32 +: 32], sb[k].size() != 0, e);
                end
            end
            tick();
        end
    endtask

    task automatic test_stream();
        logic [31:0] e;
        int em [4];
        em = '{0, 0, 0, 0};
        for (int i = 0; i < 17; i++) begin
            set_in(i < 16, 2'(i % 4), 1'b0, 32'(i), 4'hF);
            n_cmp++;
            if (o_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d]: got %b want 1", i, o_ready); end
            for (int k = 0; k < 4; k++) begin
                e = sb[k].size() != 0 ? sb[k][0] : 32'h0;
                n_cmp++;
                if (o_valid[k] !== (sb[k].size() != 0) || o_data[k*32 +: 32] !== e) begin
                    n_fail++;
                    $display("FAIL stream[%0d] lane%0d: got v=%b d=%h want v=%b d=%h", i, k, o_valid[k], o_data[k*32 +: 32], sb[k].size() != 0, e);
                end
                if (o_valid[k]) em[k]++;
            end
            if (i > 0) begin
                n_cmp++;
                if (o_valid[(i-1)%4] !== 1'b1 || o_data[((i-1)%4)*32 +: 32] !== 32'(i-1)) begin
                    n_fail++;
                    $display("FAIL stream_latency[%0d]: got v=%b d=%h want v=1 d=%h", i, o_valid[(i-1)%4], o_data[((i-1)%4)*32 +: 32], i-1);
                end
            end
            tick();
        end
        n_cmp++;
        if (em[0] != 4 || em[1] != 4 || em[2] != 4 || em[3] != 4 || o_valid !== 4'h0) begin
            n_fail++;
            $display("FAIL stream_counts: got %0d %0d %0d %0d v=%h want 4 each, v=0", em[0], em[1], em[2], em[3], o_valid);
        end
    endtask

    task automatic test_drop();
        set_in(1'b0, 2'd0, 1'b0, 32'h0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_dest  = 2'd3;
            s_data  = 32'hC0 + 32'(i);
            #1;
            n_cmp++;
            if (s_ready_a !== 1'b1 || s_ready_b !== 1'b1) begin n_fail++; $display("FAIL drop_ready[%0d]: got %b/%b want 1/1", i, s_ready_a, s_ready_b); end
            tick();
        end
        s_valid = 1'b0;
        #1;
        n_cmp++;
        if (s_valid_a !== 3'b0 || s_valid_b !== 3'b0 || s_data_a !== 96'h0) begin n_fail++; $display("FAIL drop_lanes: got %b/%b want 000/000", s_valid_a, s_valid_b); end
        n_cmp++;
        if (s_drop_a !== 16'(drop_a) || drop_a != 5) begin n_fail++; $display("FAIL drop_cnt: got %0d want 5", s_drop_a); end
        n_cmp++;
        if (s_drop_b !== 2'(drop_b) || drop_b != 3) begin n_fail++; $display("FAIL drop_cnt_sat: got %0d want 3", s_drop_b); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] e;
        set_in(1'b1, 2'd0, 1'b0, 32'h20, 4'h0);
        tick();
        set_in(1'b1, 2'd0, 1'b0, 32'h21, 4'h0);
        tick();
        set_in(1'b1, 2'd1, 1'b0, 32'h30, 4'h0);
        tick();
        set_in(1'b1, 2'd1, 1'b0, 32'h31, 4'h0);
        tick();
        rst = 1'b0;
        set_in(1'b0, 2'd0, 1'b0, 32'h0, 4'h0);
        n_cmp++;
        if (o_valid !== 4'b0011 || o_data[63:0] !== {32'h30, 32'h20} || o_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_prereset: got v=%b d=%h r=%b want 0011/30_20/0", o_valid, o_data[63:0], o_ready);
        end
        tick();
        rst = 1'b1;
        #1;
        n_cmp++;
        if (o_valid !== 4'h0 || o_data !== 128'h0) begin n_fail++; $display("FAIL mid_reset_lanes: got v=%h d=%h want 0", o_valid, o_data); end
        n_cmp++;
        if (o_drop_cnt !== 16'h0 || s_drop_a !== 16'h0 || s_drop_b !== 2'h0) begin n_fail++; $display("FAIL mid_reset_drop: got %0d/%0d/%0d want 0", o_drop_cnt, s_drop_a, s_drop_b); end
        set_in(1'b1, 2'd0, 1'b0, 32'h77, 4'h0);
        n_cmp++;
        if (o_ready !== 1'b1) begin n_fail++; $display("FAIL mid_after_ready: got %b want 1", o_ready); end
        tick();
        set_in(1'b0, 2'd0, 1'b0, 32'h0, 4'b0001);
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < 4; k++) begin
                e = sb[k].size() != 0 ? sb[k][0] : 32'h0;
                n_cmp++;
                if (o_valid[k] !== (sb[k].size() != 0) || o_data[k*32 +: 32] !== e) begin
                    n_fail++;
                    $display("FAIL mid_after lane%0d: got v=%b d=%h want v=%b d=%h", k, o_valid[k], o_data[k*32 +: 32], sb[k].size() != 0, e);
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_unicast_fill();
        test_pop_refill();
        test_bcast();
        test_stream();
        test_drop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
